alu_muldiv_iter: RTL and testbench
==================================

// Module: alu_muldiv_iter
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit executing the RV32M op set (MUL..REMU) beside the
//  single-cycle ALU. Iterative radix-2 shift-add / restoring-divide datapath behind valid/ready
//  handshakes. Holds its result until the consumer accepts it; the pipeline stalls on o_ready=0.
//  Divide-by-zero and signed overflow resolve on a fast path with fixed latency.
// PARAMETERS
//  XLEN      32  operand/result width (>=8, even)
//  CNT_W     $clog2(XLEN+1)  iteration counter width (derived, not overridden)
// PORTS
//  i_clk      in   1     clock, all state on rising edge
//  i_rst_n    in   1     synchronous active-low reset
//  i_valid    in   1     request valid
//  o_ready    out  1     unit can accept a request (state IDLE)
//  i_md_op    in   3     op: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  i_op_a     in   XLEN  rs1 operand (multiplicand / dividend)
//  i_op_b     in   XLEN  rs2 operand (multiplier / divisor)
//  i_flush    in   1     abort in-flight op, return to IDLE next cycle
//  o_valid    out  1     result valid (state DONE)
//  i_ready    in   1     consumer accepts result
//  o_md_data  out  XLEN  result
//  o_busy     out  1     state != IDLE
// BEHAVIOUR
//  - Reset (i_rst_n=0 at edge): state=IDLE, o_valid=0, o_ready=1 after reset, o_busy=0, o_md_data=0,
//    counter=0. Reset mid-operation discards the op with no result.
//  - FSM: IDLE -> CALC when i_valid&o_ready; IDLE -> DONE directly on fast path;
//    CALC -> FIX when counter==XLEN-1; FIX -> DONE; DONE -> IDLE when i_ready.
//    i_flush has priority over everything except reset: any state -> IDLE, o_valid=0.
//  - Accept: operands latched. Signed ops (MULH/DIV/REM: both; MULHSU: a only) convert to magnitude
//    and record result sign (mul: sa^sb; quotient: sa^sb; remainder: sa).
//  - CALC: one iteration/cycle, XLEN cycles. Mul: 2*XLEN product reg, add then shift right.
//    Div: (XLEN+1)-bit restoring subtract, shift quotient bit in.
//  - FIX: apply two's-complement negation per recorded sign, select low (MUL) / high (MULH*) half,
//    quotient (DIV*) or remainder (REM*). Register into o_md_data.
//  - Latency: request accepted at edge T -> o_valid=1 from edge T+XLEN+2 (34 for XLEN=32).
//  - Fast path (div ops only), o_valid from edge T+1:
//    divisor==0 -> DIV/DIVU quotient all-ones, REM/REMU = dividend.
//    DIV/REM with a=most-negative, b=-1 -> quotient=a, remainder=0.
//  - DONE: o_md_data and o_valid stable until i_ready; i_valid ignored (o_ready=0).
//    Back-to-back: a new request is accepted no earlier than the cycle after the DONE handshake.
//  - o_md_data holds last result in IDLE; it is undefined in CALC/FIX and is not checked there.
//  - All arithmetic is modulo widths stated; no X propagation from unused operand bits.
// STRUCTURE
//  - Shared package alu_pkg: md_op_e enum (3-bit, values above), md_state_e {IDLE,CALC,FIX,DONE},
//    helper function is_div(op)/is_signed_a(op)/is_signed_b(op).
//  - One sub-module: muldiv_step (combinational XLEN+1-bit add/sub step shared by mul and div
//    iterations); FSM, counter and sign fix-up stay in alu_muldiv_iter.
// TESTING
//  - MUL 7*-3 (0x7,0xFFFFFFFD) -> 0xFFFFFFEB, o_valid exactly 34 cycles after accept.
//  - MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//    MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  - DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  - Fast path: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000,
//    REM of the same pair -> 0; each with o_valid one cycle after accept.
//  - Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_md_data/o_valid stable,
//    o_ready=0, a new i_valid is not accepted.
//  - i_flush at CALC cycle 5, then i_rst_n=0 mid-CALC: both -> IDLE next edge, o_valid never
//    asserts; the next request completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op and state encodings plus small op-classification helpers.
package alu_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  function automatic logic is_signed_a(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic is_signed_b(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational (XLEN+1)-bit add/subtract step shared by the shift-add
// multiply and the restoring divide iterations.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0] a,
  input  logic [XLEN:0] b,
  input  logic          sub,
  output logic [XLEN:0] res
);

  assign res = a + (sub ? ~b : b) + {{XLEN{1'b0}}, sub};

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 RV32M multiply/divide unit with valid/ready handshakes,
// a fixed-latency fast path for divide-by-zero and signed overflow.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_md_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_md_data,
  output logic            o_busy
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state, state_nxt;
  md_op_e            op_in, op_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] prod, prod_nxt, prod_neg, prod_sel;
  logic [XLEN-1:0]   opnd;
  logic              neg_q;

  logic              sa, sb, accept, fast;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res, rem_neg, fix_res;
  logic [XLEN:0]     step_a, step_b, step_res;
  logic              step_sub;

  assign op_in   = md_op_e'(i_md_op);
  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_busy  = (state != IDLE);
  assign accept  = o_ready && i_valid && !i_flush;

  // Operand conditioning and fast-path detection at the accept boundary.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    fast     = 1'b0;
    fast_res = '0;
    sa       = is_signed_a(op_in) & i_op_a[XLEN-1];
    sb       = is_signed_b(op_in) & i_op_b[XLEN-1];
    mag_a    = sa ? (~i_op_a + XLEN'(1)) : i_op_a;
    mag_b    = sb ? (~i_op_b + XLEN'(1)) : i_op_b;
    if (is_div(op_in)) begin
      if (i_op_b == '0) begin
        fast     = 1'b1;
        fast_res = is_rem(op_in) ? i_op_a : '1;
      end else if (is_signed_b(op_in) && i_op_a == MOST_NEG && i_op_b == '1) begin
        fast     = 1'b1;
        fast_res = is_rem(op_in) ? '0 : i_op_a;
      end
    end
  end

  // Mul: upper half plus multiplicand when the current multiplier bit is set.
  // Div: shift the next dividend bit into the partial remainder, subtract divisor.
  always_comb begin
    step_sub = is_div(op_q);
    if (step_sub) begin
      step_a = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
      step_b = {1'b0, opnd};
    end else begin
      step_a = {1'b0, prod[2*XLEN-1:XLEN]};
      step_b = prod[0] ? {1'b0, opnd} : '0;
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .a   (step_a),
    .b   (step_b),
    .sub (step_sub),
    .res (step_res)
  );

  always_comb begin
    if (step_sub) begin
      prod_nxt = step_res[XLEN] ? {prod[2*XLEN-2:0], 1'b0}
                                : {step_res[XLEN-1:0], prod[XLEN-2:0], 1'b1};
    end else begin
      prod_nxt = {step_res, prod[XLEN-1:1]};
    end
  end

  // Sign fix-up: quotient sits in the low half, remainder in the high half.
  always_comb begin
    prod_neg = ~prod + (2*XLEN)'(1);
    rem_neg  = ~prod[2*XLEN-1:XLEN] + XLEN'(1);
    prod_sel = neg_q ? prod_neg : prod;
    unique case (op_q)
      MD_MUL, MD_DIV, MD_DIVU:       fix_res = prod_sel[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_res = prod_sel[2*XLEN-1:XLEN];
      default:                       fix_res = neg_q ? rem_neg : prod[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_valid) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(XLEN - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch, not in the sensitivity list.
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst_n) begin
      op_q      <= MD_MUL;
      neg_q     <= 1'b0;
      cnt       <= '0;
      prod      <= '0;
      opnd      <= '0;
      o_md_data <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      neg_q <= is_rem(op_in) ? sa : (sa ^ sb);
      cnt   <= '0;
      if (is_div(op_in)) begin
        prod <= {{XLEN{1'b0}}, mag_a};
        opnd <= mag_b;
      end else begin
        prod <= {{XLEN{1'b0}}, mag_b};
        opnd <= mag_a;
      end
      if (fast) o_md_data <= fast_res;
    end else if (!i_flush) begin
      if (state == CALC) begin
        cnt  <= cnt + CNT_W'(1);
        prod <= prod_nxt;
      end else if (state == FIX) begin
        o_md_data <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Self-checking bench for alu_muldiv_iter: spec vector table, random ops against a
// 64-bit reference model, and hand-written backpressure / flush / reset sequences.
module tb_alu_muldiv_iter;

  localparam int XLEN = 32;
  localparam int CALC_LAT = XLEN + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      md_op;
  logic [XLEN-1:0] op_a, op_b;
  logic            flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] md_data;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        fast;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  alu_muldiv_iter #(.XLEN(XLEN)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_md_op   (md_op),
    .i_op_a    (op_a),
    .i_op_b    (op_b),
    .i_flush   (flush),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_md_data (md_data),
    .o_busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, su, sp;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    su  = ub;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (op)
      3'd0: begin sp = sa * sb; p = sp; model = p[31:0];  end
      3'd1: begin sp = sa * sb; p = sp; model = p[63:32]; end
      3'd2: begin sp = sa * su; p = sp; model = p[63:32]; end
      3'd3: begin p = ua * ub; model = p[63:32]; end
      3'd4: begin
        if (b == 0) model = '1;
        else if (ovf) model = a;
        else begin sp = sa / sb; p = sp; model = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) model = '1;
        else begin p = ua / ub; model = p[31:0]; end
      end
      3'd6: begin
        if (b == 0) model = a;
        else if (ovf) model = '0;
        else begin sp = sa % sb; p = sp; model = p[31:0]; end
      end
      default: begin
        if (b == 0) model = a;
        else begin p = ua % ub; model = p[31:0]; end
      end
    endcase
  endfunction

  function automatic logic is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Drive one request, push its expectation, check latency and result at the handshake.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic fast);
    int lat;
    logic [31:0] want;
    @(negedge clk);
    md_op = op; op_a = a; op_b = b; i_valid = 1'b1; i_ready = 1'b1;
    check({name, "_ready"}, 32'(o_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(exp);
    #1 i_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({name, "_busy"}, 32'(busy), 32'd1);
      if (o_valid) break;
      if (lat > 3 * CALC_LAT) begin
        failures++;
        $display("FAIL %s_timeout: o_valid absent after %0d cycles", name, lat);
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), fast ? 32'd1 : 32'(CALC_LAT));
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s_underflow: result with empty scoreboard", name);
    end else begin
      want = sb_q.pop_front();
      check({name, "_data"}, md_data, want);
    end
    @(posedge clk);
    #1;
  endtask

  // Accept a request with no expectation queued; used before deliberate aborts.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_op = op; op_a = a; op_b = b; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    check({name, "_no_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1'b1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[12] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[13] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[14] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0};
    vecs[15] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0};

    rst_n = 1'b0; i_valid = 1'b0; md_op = '0; op_a = '0; op_b = '0;
    flush = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_data",  md_data,      32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].fast);

    for (int i = 0; i < 10; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      run_op($sformatf("rnd%0d", i), op, a, b, model(op, a, b), is_fast(op, a, b));
    end

    // Backpressure: consumer stalls for 10 cycles while a new request is presented.
    begin
      int lat = 0;
      logic [31:0] want;
      @(negedge clk);
      md_op = 3'd5; op_a = 32'd100; op_b = 32'd7; i_valid = 1'b1; i_ready = 1'b0;
      @(posedge clk);
      sb_q.push_back(32'd14);
      #1 i_valid = 1'b0;
      while (!o_valid && lat <= 3 * CALC_LAT) begin
        @(negedge clk);
        lat++;
      end
      check("bp_latency", 32'(lat), 32'(CALC_LAT));
      md_op = 3'd0; op_a = 32'd3; op_b = 32'd3; i_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check($sformatf("bp_valid%0d", k), 32'(o_valid), 32'd1);
        check($sformatf("bp_data%0d", k),  md_data,      32'd14);
        check($sformatf("bp_ready%0d", k), 32'(o_ready), 32'd0);
      end
      i_valid = 1'b0; i_ready = 1'b1;
      want = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      check("bp_result", md_data, want);
      @(negedge clk);
      check("bp_after_valid", 32'(o_valid), 32'd0);
      check("bp_after_busy",  32'(busy),    32'd0);
      check("bp_hold_data",   md_data,      32'd14);
    end

    // Flush during CALC cycle 5.
    start_op(3'd0, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy",  32'(busy),    32'd0);
    check("flush_ready", 32'(o_ready), 32'd1);
    watch_no_valid("flush", 2 * CALC_LAT);

    // Reset mid-CALC.
    start_op(3'd4, 32'd1000, 32'd10);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_busy",  32'(busy),    32'd0);
    check("rstmid_ready", 32'(o_ready), 32'd1);
    check("rstmid_data",  md_data,      32'd0);
    watch_no_valid("rstmid", 2 * CALC_LAT);

    run_op("post_abort", 3'd4, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 1'b0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
